// File: rtl/simon_key_sched.sv
// simon_key_sched: Simon 128/256 key-expansion writer.
// Expands a 256-bit master key into 72 round keys, one per clock, and
// streams them into the round-key RAM at address = round index.
module simon_key_sched #(
  parameter int          NKEYS = 72,
  parameter logic [61:0] Z4    = 62'b11010001111001101011011000100000010111000011001010010011101111
) (
  input  logic         clk,
  input  logic         res,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         we,
  output logic [6:0]   wr_adr,
  output logic [63:0]  wr_data,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GEN  = 3'b010,
    FIN  = 3'b100
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] r0_q, r1_q, r2_q, r3_q;
  logic [63:0] r0_d, r1_d, r2_d, r3_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  zIdx_q, zIdx_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [6:0]  adr_q, adr_d;
  logic [63:0] data_q, data_d;

  logic        zBit;
  logic [63:0] rotMix;
  logic [63:0] tMix;
  logic [63:0] newWord;

  // Round-constant bit and next schedule word. z[j] is the j-th character
  // from the left of Z4, so it lives at bit 61-j. zIdx tracks cnt mod 62.
  always_comb begin
    zBit    = Z4[6'd61 - zIdx_q];
    rotMix  = {r3_q[2:0], r3_q[63:3]} ^ r1_q;
    tMix    = rotMix ^ {rotMix[0], rotMix[63:1]};
    newWord = ~r0_q ^ tMix ^ 64'h3 ^ {63'b0, zBit};
  end

  // Next-state, datapath and registered-output decode. Outputs are computed
  // for the cycle that follows the edge, so each write appears from flops.
  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    cnt_d   = cnt_q;
    zIdx_d  = zIdx_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    adr_d   = 7'd0;
    data_d  = 64'd0;

    unique case (state_q)
      IDLE, FIN: begin
        if (start) begin
          r0_d    = key_in[63:0];
          r1_d    = key_in[127:64];
          r2_d    = key_in[191:128];
          r3_d    = key_in[255:192];
          cnt_d   = 7'd0;
          zIdx_d  = 6'd0;
          state_d = GEN;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          adr_d   = 7'd0;
          data_d  = key_in[63:0];
        end else if (state_q == FIN) begin
          done_d = 1'b1;
        end
      end
      GEN: begin
        r0_d   = r1_q;
        r1_d   = r2_q;
        r2_d   = r3_q;
        r3_d   = newWord;
        cnt_d  = cnt_q + 7'd1;
        zIdx_d = (zIdx_q == 6'd61) ? 6'd0 : zIdx_q + 6'd1;
        if (cnt_q == 7'(NKEYS - 1)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          adr_d  = cnt_q + 7'd1;
          data_d = r1_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output flops; reset clears everything at once so
  // an abort mid-expansion drops we without waiting for a clock edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      r0_q    <= 64'd0;
      r1_q    <= 64'd0;
      r2_q    <= 64'd0;
      r3_q    <= 64'd0;
      cnt_q   <= 7'd0;
      zIdx_q  <= 6'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= 7'd0;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      cnt_q   <= cnt_d;
      zIdx_q  <= zIdx_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
    end
  end

  assign we      = we_q;
  assign wr_adr  = adr_q;
  assign wr_data = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/simon_key_sched.md
Name: simon_key_sched

Overview:
- Key-expansion writer for the Simon 128/256 datapath.
- Takes a 256-bit master key and computes all 72 round keys, one per clock.
- Writes each round key into the round-key RAM at address = round index (0..71).
- The encrypt/decrypt core later reads the keys back from that RAM by address.

Parameters:
NKEYS, 72, number of round keys generated and written (Simon 128/256)
Z4, 62'b11010001111001101011011000100000010111000011001010010011101111, Simon z4 constant sequence; z[j] is the j-th character from the left, j=0..61

Ports:
clk  in  1  clock, all state on rising edge
res  in  1  asynchronous active-high reset
start  in  1  request expansion; sampled only in IDLE or FIN
key_in  in  256  master key; key_in[63:0]=k0, [127:64]=k1, [191:128]=k2, [255:192]=k3
we  out  1  round-key RAM write enable
wr_adr  out  7  round-key RAM write address
wr_data  out  64  round key being written
busy  out  1  high while in GEN
done  out  1  high in FIN; all NKEYS keys written

Behaviour:
- Reset (async, res=1): state=IDLE, cnt=0, k0..k3=0, we=0, wr_adr=0, wr_data=0, busy=0, done=0. Takes effect immediately, including mid-GEN; we must drop without waiting for a clock edge.
- State register: 3 states, one-hot: IDLE, GEN, FIN.
- Datapath: four 64-bit word registers r0..r3 (window k[i]..k[i+3]) and a 7-bit counter cnt.
- Next word, rotations on 64 bits: t = ROR3(r3) ^ r1; t = t ^ ROR1(t); new = ~r0 ^ t ^ 64'h3 ^ {63'b0, z[cnt mod 62]}.
- cnt mod 62 is implemented as a separate 6-bit index that wraps 61->0. No divider.
- IDLE:
  - start=1: capture r0..r3 from key_in, cnt<=0, go to GEN.
  - Otherwise hold; outputs 0.
- GEN, every cycle:
  - we=1, wr_adr=cnt, wr_data=r0 (registered values, so the write is visible in the same cycle).
  - Shift: r0<=r1, r1<=r2, r2<=r3, r3<=new, cnt<=cnt+1.
  - When cnt==NKEYS-1, the current write is the last: go to FIN.
  - start is ignored in GEN; key_in is not re-sampled.
- FIN:
  - done=1, we=0, busy=0.
  - start=1: re-capture key_in, clear done, go to GEN (back-to-back re-key allowed).
  - Otherwise stay in FIN indefinitely.
- Output decode is registered: we/busy/done/wr_adr/wr_data are flops driven from next-state logic. No combinational path from start or key_in to any output.
- Timing:
  - start sampled at edge E0.
  - First write (adr 0, k0) is visible in cycle E0..E1.
  - Last write (adr 71) is visible in cycle E71..E72.
  - done=1 from E72.
  - Exactly 72 consecutive write cycles, addresses strictly 0,1,...,71, no gaps or repeats.
- Words k72..k75 are computed into r3 during the final cycles but never written.
- we is never high outside GEN.

Test Plan:
- Reset then hold res=1 with start=1 for 5 cycles -> we=0, done=0, busy=0 throughout; no state change.
- Key 1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100, start pulse:
  - we high exactly 72 cycles.
  - adr0=0706050403020100, adr1=0f0e0d0c0b0a0908, adr2=1716151413121110, adr3=1f1e1d1c1b1a1918.
  - adr4..71 match the C golden model bit-exactly.
  - done rises the cycle after adr 71.
- Same key expansion, then the encrypt core run on plaintext 74206e69206d6f6f_6d69732061207369 -> ciphertext 8d2b5579afc8a3a0_3bf72a87efe7b868. Decrypt of that ciphertext returns the plaintext.
- Assert res for one cycle at cnt==30 (asynchronously, mid-cycle) -> we falls before the next edge, all outputs 0, state IDLE. A new start regenerates adr 0..71 from the start.
- start held high continuously through GEN with key_in changed mid-run -> keys written match the key captured at the first start only.
- From FIN, start with a different key -> done clears on the next edge and a fresh 72-write burst follows. z index wrap (61->0 at cnt 62) matches the golden model for adr 66..71.
